// File: rtl/uart_pkg.sv
// Shared definitions for the UART family: parity encodings, transmitter state
// encodings, the prescale-to-bit-period shift and small helper functions.
package uart_pkg;

    localparam logic [2:0] UART_PAR_NONE  = 3'd0;
    localparam logic [2:0] UART_PAR_EVEN  = 3'd1;
    localparam logic [2:0] UART_PAR_ODD   = 3'd2;
    localparam logic [2:0] UART_PAR_MARK  = 3'd3;
    localparam logic [2:0] UART_PAR_SPACE = 3'd4;

    localparam int PRESCALE_SHIFT = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_e;

    // A prescale of zero behaves like one so the bit period never collapses.
    function automatic logic [18:0] uart_bit_period(input logic [15:0] prescale);
        logic [18:0] period;
        if (prescale == 16'd0) begin
            period = 19'd1 << PRESCALE_SHIFT;
        end else begin
            period = {3'b000, prescale} << PRESCALE_SHIFT;
        end
        return period;
    endfunction

    // Returns {parity_enable, parity_bit}; data_xor is the XOR of all data bits.
    function automatic logic [1:0] uart_parity(input logic [2:0] mode, input logic data_xor);
        logic [1:0] res;
        case (mode)
            UART_PAR_EVEN:  res = {1'b1, data_xor};
            UART_PAR_ODD:   res = {1'b1, ~data_xor};
            UART_PAR_MARK:  res = {1'b1, 1'b1};
            UART_PAR_SPACE: res = {1'b1, 1'b0};
            default:        res = {1'b0, 1'b0};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Reloadable 19-bit bit-period down-counter; tick marks the last cycle of each
// bit period and the counter reloads automatically from period.
module uart_bit_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [18:0] period,
    output logic        tick
);

    logic [18:0] cnt_r;
    logic [18:0] reload_s;

    assign reload_s = (period == 19'd0) ? 19'd0 : (period - 19'd1);
    assign tick     = (cnt_r == 19'd0);

    // Down-counter: explicit load restarts a period, reaching zero starts the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 19'd0;
        end else if (load) begin
            cnt_r <= reload_s;
        end else if (cnt_r == 19'd0) begin
            cnt_r <= reload_s;
        end else begin
            cnt_r <= cnt_r - 19'd1;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// AXI4-Stream to UART transmitter with run-time parity, stop-bit count and
// break control; frame format and bit period are captured at each handshake.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  txd,
    output logic                  busy,
    input  logic [2:0]            parity_mode,
    input  logic                  stop2,
    input  logic                  tx_break,
    input  logic [15:0]           prescale
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    uart_state_e           state_r, state_nxt;
    logic                  txd_r, txd_nxt;
    logic                  tready_r, tready_nxt;
    logic                  busy_r, busy_nxt;
    logic [DATA_WIDTH-1:0] shreg_r, shreg_nxt;
    logic [3:0]            bit_cnt_r, bit_cnt_nxt;
    logic                  par_en_r, par_en_nxt;
    logic                  par_bit_r, par_bit_nxt;
    logic                  stop2_r, stop2_nxt;
    logic                  stop_left_r, stop_left_nxt;
    logic [18:0]           bp_r, bp_nxt;
    logic [18:0]           bp_in_s;
    logic [18:0]           timer_period_s;
    logic [1:0]            par_s;
    logic                  load_s;
    logic                  tick_s;

    assign bp_in_s        = uart_bit_period(prescale);
    assign par_s          = uart_parity(parity_mode, ^s_axis_tdata);
    // While idle the timer follows the live prescale so a load at handshake uses it directly.
    assign timer_period_s = (state_r == ST_IDLE) ? bp_in_s : bp_r;

    uart_bit_timer u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (load_s),
        .period (timer_period_s),
        .tick   (tick_s)
    );

    // Next-state, datapath and next-output logic for the frame sequencer.
    always_comb begin
        state_nxt     = state_r;
        txd_nxt       = txd_r;
        shreg_nxt     = shreg_r;
        bit_cnt_nxt   = bit_cnt_r;
        par_en_nxt    = par_en_r;
        par_bit_nxt   = par_bit_r;
        stop2_nxt     = stop2_r;
        stop_left_nxt = stop_left_r;
        bp_nxt        = bp_r;
        load_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                txd_nxt = 1'b1;
                if (tx_break) begin
                    state_nxt = ST_BREAK;
                    txd_nxt   = 1'b0;
                    bp_nxt    = bp_in_s;
                    load_s    = 1'b1;
                end else if (s_axis_tvalid && tready_r) begin
                    state_nxt   = ST_START;
                    txd_nxt     = 1'b0;
                    shreg_nxt   = s_axis_tdata;
                    bit_cnt_nxt = 4'd0;
                    par_en_nxt  = par_s[1];
                    par_bit_nxt = par_s[0];
                    stop2_nxt   = stop2;
                    bp_nxt      = bp_in_s;
                    load_s      = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    state_nxt   = ST_DATA;
                    txd_nxt     = shreg_r[0];
                    shreg_nxt   = shreg_r >> 1;
                    bit_cnt_nxt = 4'd0;
                end else begin
                    state_nxt = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    if (bit_cnt_r == LAST_BIT) begin
                        if (par_en_r) begin
                            state_nxt = ST_PARITY;
                            txd_nxt   = par_bit_r;
                        end else begin
                            state_nxt     = ST_STOP;
                            txd_nxt       = 1'b1;
                            stop_left_nxt = stop2_r;
                        end
                    end else begin
                        txd_nxt     = shreg_r[0];
                        shreg_nxt   = shreg_r >> 1;
                        bit_cnt_nxt = bit_cnt_r + 4'd1;
                    end
                end else begin
                    state_nxt = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tick_s) begin
                    state_nxt     = ST_STOP;
                    txd_nxt       = 1'b1;
                    stop_left_nxt = stop2_r;
                end else begin
                    state_nxt = ST_PARITY;
                end
            end
            ST_STOP: begin
                txd_nxt = 1'b1;
                if (tick_s) begin
                    if (stop_left_r) begin
                        stop_left_nxt = 1'b0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    state_nxt = ST_STOP;
                end
            end
            ST_BREAK: begin
                txd_nxt = 1'b0;
                // Release is followed by one mark bit, reusing STOP with no extra bit pending.
                if (!tx_break) begin
                    state_nxt     = ST_STOP;
                    txd_nxt       = 1'b1;
                    stop_left_nxt = 1'b0;
                    load_s        = 1'b1;
                end else begin
                    state_nxt = ST_BREAK;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                txd_nxt   = 1'b1;
            end
        endcase
        tready_nxt = (state_nxt == ST_IDLE);
        busy_nxt   = (state_nxt != ST_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            txd_r       <= 1'b1;
            tready_r    <= 1'b0;
            busy_r      <= 1'b0;
            shreg_r     <= '0;
            bit_cnt_r   <= 4'd0;
            par_en_r    <= 1'b0;
            par_bit_r   <= 1'b0;
            stop2_r     <= 1'b0;
            stop_left_r <= 1'b0;
            bp_r        <= 19'd0;
        end else begin
            state_r     <= state_nxt;
            txd_r       <= txd_nxt;
            tready_r    <= tready_nxt;
            busy_r      <= busy_nxt;
            shreg_r     <= shreg_nxt;
            bit_cnt_r   <= bit_cnt_nxt;
            par_en_r    <= par_en_nxt;
            par_bit_r   <= par_bit_nxt;
            stop2_r     <= stop2_nxt;
            stop_left_r <= stop_left_nxt;
            bp_r        <= bp_nxt;
        end
    end

    assign s_axis_tready = tready_r;
    assign txd           = txd_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: an 8-bit and a 7-bit instance share clock,
// reset and frame configuration; expected frames are written out bit by bit.
module tb_uart_tx_frame;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready, txd, busy;
    logic [6:0]  tdata7;
    logic        tvalid7;
    logic        tready7, txd7, busy7;
    logic [2:0]  parity_mode;
    logic        stop2;
    logic        tx_break;
    logic [15:0] prescale;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
        .s_axis_tready(tready), .txd(txd), .busy(busy), .parity_mode(parity_mode),
        .stop2(stop2), .tx_break(tx_break), .prescale(prescale)
    );

    uart_tx_frame #(.DATA_WIDTH(7)) dut7 (
        .clk(clk), .rst(rst), .s_axis_tdata(tdata7), .s_axis_tvalid(tvalid7),
        .s_axis_tready(tready7), .txd(txd7), .busy(busy7), .parity_mode(parity_mode),
        .stop2(stop2), .tx_break(tx_break), .prescale(prescale)
    );

    function automatic logic cur_ready(input bit sel);
        return sel ? tready7 : tready;
    endfunction

    function automatic logic cur_txd(input bit sel);
        return sel ? txd7 : txd;
    endfunction

    function automatic logic cur_busy(input bit sel);
        return sel ? busy7 : busy;
    endfunction

    task automatic set_cfg(input logic [2:0] pm, input logic s2, input logic [15:0] ps);
        parity_mode = pm;
        stop2       = s2;
        prescale    = ps;
    endtask

    // ev_kind 1: change config at sample ev_at; ev_kind 2: raise tx_break at sample ev_at.
    task automatic send_frame(input string name, input bit sel, input logic [7:0] data,
                              input string bits, input int bp, input int ev_kind, input int ev_at);
        int  k;
        int  wait_n;
        logic exp;
        logic got;
        bit  bad;
        wait_n = 0;
        while (cur_ready(sel) !== 1'b1 && wait_n < 2000) begin
            @(negedge clk);
            wait_n++;
        end
        checks++;
        if (cur_ready(sel) !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_timeout: tready=%b required 1", name, cur_ready(sel));
            return;
        end
        if (sel) begin
            tdata7  = data[6:0];
            tvalid7 = 1'b1;
        end else begin
            tdata  = data;
            tvalid = 1'b1;
        end
        @(negedge clk);
        tvalid  = 1'b0;
        tvalid7 = 1'b0;
        checks++;
        if (cur_busy(sel) !== 1'b1 || cur_ready(sel) !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: busy=%b tready=%b required busy=1 tready=0",
                     name, cur_busy(sel), cur_ready(sel));
        end
        k = 0;
        for (int i = 0; i < bits.len(); i++) begin
            exp = (bits.getc(i) == 8'h31);
            bad = 1'b0;
            got = exp;
            for (int c = 0; c < bp; c++) begin
                if (k == ev_at && ev_kind == 1) begin
                    prescale    = 16'd3;
                    parity_mode = 3'd1;
                    stop2       = 1'b1;
                end else if (k == ev_at && ev_kind == 2) begin
                    tx_break = 1'b1;
                end
                if (cur_txd(sel) !== exp) begin
                    bad = 1'b1;
                    got = cur_txd(sel);
                end
                @(negedge clk);
                k++;
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL %s bit%0d: txd=%b required %b", name, i, got, exp);
            end
        end
        checks++;
        if (cur_ready(sel) !== 1'b1 || cur_busy(sel) !== 1'b0 || cur_txd(sel) !== 1'b1) begin
            errors++;
            $display("FAIL %s end: tready=%b busy=%b txd=%b required 1 0 1",
                     name, cur_ready(sel), cur_busy(sel), cur_txd(sel));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tdata = 8'h00; tvalid = 1'b0; tdata7 = 7'h00; tvalid7 = 1'b0;
        tx_break = 1'b0;
        set_cfg(3'd0, 1'b0, 16'd1);
        repeat (3) @(negedge clk);
        checks++;
        if (txd !== 1'b1 || tready !== 1'b0 || busy !== 1'b0 ||
            txd7 !== 1'b1 || tready7 !== 1'b0 || busy7 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: txd=%b tready=%b busy=%b txd7=%b tready7=%b busy7=%b required 1 0 0 1 0 0",
                     txd, tready, busy, txd7, tready7, busy7);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (tready !== 1'b1 || busy !== 1'b0 || txd !== 1'b1 || tready7 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: tready=%b busy=%b txd=%b tready7=%b required 1 0 1 1",
                     tready, busy, txd, tready7);
        end
    endtask

    task automatic test_formats();
        set_cfg(3'd0, 1'b0, 16'd1);
        send_frame("8N1_55", 1'b0, 8'h55, "0101010101", 8, 0, -1);
        set_cfg(3'd1, 1'b1, 16'd2);
        send_frame("8E2_07", 1'b0, 8'h07, "011100000111", 16, 0, -1);
        set_cfg(3'd2, 1'b0, 16'd1);
        send_frame("7O1_00", 1'b1, 8'h00, "0000000011", 8, 0, -1);
        set_cfg(3'd3, 1'b0, 16'd1);
        send_frame("mark_00", 1'b0, 8'h00, "00000000011", 8, 0, -1);
        set_cfg(3'd4, 1'b0, 16'd1);
        send_frame("space_FF", 1'b0, 8'hFF, "01111111101", 8, 0, -1);
        set_cfg(3'd5, 1'b0, 16'd0);
        send_frame("ps0_mode5_A5", 1'b0, 8'hA5, "0101001011", 8, 0, -1);
    endtask

    task automatic test_config_change();
        set_cfg(3'd0, 1'b0, 16'd1);
        send_frame("midframe_cfg", 1'b0, 8'h0F, "0111100001", 8, 1, 20);
        set_cfg(3'd0, 1'b0, 16'd1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] w [3];
        int  hs;
        int  f;
        int  pos;
        int  b;
        int  wait_n;
        logic exp_txd;
        logic exp_rdy;
        w[0] = 8'h31; w[1] = 8'hC8; w[2] = 8'h0F;
        set_cfg(3'd0, 1'b0, 16'd1);
        wait_n = 0;
        while (tready !== 1'b1 && wait_n < 2000) begin
            @(negedge clk);
            wait_n++;
        end
        tdata  = w[0];
        tvalid = 1'b1;
        hs = (tready === 1'b1) ? 1 : 0;
        @(negedge clk);
        for (int k = 0; k < 3 * 81 + 4; k++) begin
            f   = k / 81;
            pos = k % 81;
            if (pos == 0 && f < 2) begin
                tdata = w[f + 1];
            end else if (pos == 0 && f == 2) begin
                tvalid = 1'b0;
            end
            if (f >= 3) begin
                exp_txd = 1'b1;
                exp_rdy = 1'b1;
            end else if (pos < 80) begin
                b = pos / 8;
                exp_txd = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : w[f][b - 1];
                exp_rdy = 1'b0;
            end else begin
                exp_txd = 1'b1;
                exp_rdy = 1'b1;
            end
            checks++;
            if (txd !== exp_txd || tready !== exp_rdy) begin
                errors++;
                $display("FAIL b2b cycle%0d: txd=%b tready=%b required %b %b",
                         k, txd, tready, exp_txd, exp_rdy);
            end
            if (tready === 1'b1 && tvalid === 1'b1) hs++;
            @(negedge clk);
        end
        checks++;
        if (hs != 3) begin
            errors++;
            $display("FAIL b2b handshakes: count=%0d required 3", hs);
        end
    endtask

    task automatic test_break();
        int bad;
        set_cfg(3'd0, 1'b0, 16'd1);
        send_frame("break_frame", 1'b0, 8'h55, "0101010101", 8, 2, 20);
        @(negedge clk);
        checks++;
        if (txd !== 1'b0 || busy !== 1'b1 || tready !== 1'b0) begin
            errors++;
            $display("FAIL break_entry: txd=%b busy=%b tready=%b required 0 1 0", txd, busy, tready);
        end
        tdata  = 8'h00;
        tvalid = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (txd !== 1'b0 || tready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL break_hold: bad_cycles=%0d required 0", bad);
        end
        tx_break = 1'b0;
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (txd !== 1'b1 || busy !== 1'b1 || tready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL break_mark: bad_cycles=%0d required 0", bad);
        end
        checks++;
        if (tready !== 1'b1 || busy !== 1'b0 || txd !== 1'b1) begin
            errors++;
            $display("FAIL break_idle: tready=%b busy=%b txd=%b required 1 0 1", tready, busy, txd);
        end
        @(negedge clk);
        tvalid = 1'b0;
        checks++;
        if (txd !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL break_next_start: txd=%b busy=%b required 0 1", txd, busy);
        end
        repeat (90) @(negedge clk);
        checks++;
        if (tready !== 1'b1 || txd !== 1'b1) begin
            errors++;
            $display("FAIL break_next_done: tready=%b txd=%b required 1 1", tready, txd);
        end
    endtask

    task automatic test_reset_midframe();
        set_cfg(3'd0, 1'b0, 16'd1);
        tdata  = 8'h55;
        tvalid = 1'b1;
        @(negedge clk);
        tvalid = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (txd !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: txd=%b busy=%b required 0 1", txd, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0 || tready !== 1'b0) begin
            errors++;
            $display("FAIL rst_abort: txd=%b busy=%b tready=%b required 1 0 0", txd, busy, tready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (tready !== 1'b1 || busy !== 1'b0 || txd !== 1'b1) begin
            errors++;
            $display("FAIL rst_release: tready=%b busy=%b txd=%b required 1 0 1", tready, busy, txd);
        end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_config_change();
        test_back_to_back();
        test_break();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
